// File: rtl/bft_pkg.sv
// Shared definitions for the butterfly-fat-tree leaf: packet geometry helpers,
// field offsets for the default configuration and a packet packing function.
package bft_pkg;

    function automatic int addr_w_f(input int num_leaves);
        return (num_leaves > 1) ? $clog2(num_leaves) : 1;
    endfunction

    function automatic int p_sz_f(input int num_leaves, input int payload_sz);
        return 1 + addr_w_f(num_leaves) + payload_sz;
    endfunction

    localparam int NUM_LEAVES = 2;
    localparam int PAYLOAD_SZ = 1;
    localparam int ADDR_W     = addr_w_f(NUM_LEAVES);
    localparam int P_SZ       = p_sz_f(NUM_LEAVES, PAYLOAD_SZ);
    localparam int VALID_BIT  = P_SZ - 1;
    localparam int ADDR_LSB   = PAYLOAD_SZ;

    // Valid packet layout: {valid, dest, payload}; an invalid packet is all zero.
    function automatic logic [P_SZ-1:0] pack_pkt(input logic [ADDR_W-1:0]     dest,
                                                 input logic [PAYLOAD_SZ-1:0] payload);
        return {1'b1, dest, payload};
    endfunction

endpackage

// File: rtl/bft_port_fifo.sv
// Single-clock FIFO for one requester; full/empty decode from the registered
// count only, so the arbiter's pop never feeds back into req_ready.
module bft_port_fifo #(
    parameter int width = 2,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == cnt_w'(depth));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every signal gets its default before the ifs, so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
        if (do_push && !do_pop)      count_d = count_q + cnt_w'(1);
        else if (!do_push && do_pop) count_d = count_q - cnt_w'(1);
    end

    // NOTE: state updates use <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after the count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bft_leaf_inject_arb.sv
// Leaf injection scheduler: per-port FIFOs drained round-robin into one
// registered tree packet, which is held bit-identical while the tree stalls.
module bft_leaf_inject_arb
    import bft_pkg::*;
#(
    parameter  int num_leaves = NUM_LEAVES,
    parameter  int payload_sz = PAYLOAD_SZ,
    parameter  int num_ports  = 4,
    parameter  int fifo_depth = 4,
    localparam int addr_w     = addr_w_f(num_leaves),
    localparam int p_sz       = p_sz_f(num_leaves, payload_sz),
    localparam int idx_w      = $clog2(num_ports)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports-1:0]           req_valid,
    input  logic [num_ports*addr_w-1:0]    req_dest,
    input  logic [num_ports*payload_sz-1:0] req_payload,
    output logic [num_ports-1:0]           req_ready,
    input  logic                           net_stall,
    output logic [p_sz-1:0]                bus_o,
    output logic [idx_w-1:0]               grant_idx,
    output logic [15:0]                    sent_count
);
    logic [num_ports-1:0] fifo_full, fifo_empty, push, pop;
    logic [p_sz-2:0]      fifo_dout [num_ports];

    logic [p_sz-1:0]  bus_q, bus_d;
    logic [idx_w-1:0] grant_q, grant_d;
    logic [idx_w-1:0] rr_q, rr_d;
    logic [15:0]      sent_q, sent_d;
    logic             hold, found;
    logic [idx_w-1:0] cand;

    assign req_ready = ~fifo_full;
    assign push      = req_valid & ~fifo_full;

    for (genvar i = 0; i < num_ports; i++) begin : g_port
        bft_port_fifo #(
            .width(p_sz - 1),
            .depth(fifo_depth)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .push (push[i]),
            .pop  (pop[i]),
            .din  ({req_dest[i*addr_w +: addr_w], req_payload[i*payload_sz +: payload_sz]}),
            .dout (fifo_dout[i]),
            .full (fifo_full[i]),
            .empty(fifo_empty[i])
        );
    end

    always_comb begin
        hold    = bus_q[p_sz-1] && net_stall;
        found   = 1'b0;
        cand    = '0;
        pop     = '0;
        bus_d   = bus_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        sent_d  = sent_q;
        if (bus_q[p_sz-1] && !net_stall) sent_d = sent_q + 16'd1;
        if (!hold) begin
            bus_d = '0;
            // Scan starts one past the last winner, so the last winner has lowest priority.
            for (int k = 1; k <= num_ports; k++) begin
                cand = idx_w'((int'(rr_q) + k) % num_ports);
                if (!found && !fifo_empty[cand]) begin
                    found     = 1'b1;
                    pop[cand] = 1'b1;
                    bus_d     = {1'b1, fifo_dout[cand]};
                    grant_d   = cand;
                    rr_d      = cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q   <= '0;
            grant_q <= '0;
            rr_q    <= idx_w'(num_ports - 1);
            sent_q  <= '0;
        end else begin
            bus_q   <= bus_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            sent_q  <= sent_d;
        end
    end

    assign bus_o      = bus_q;
    assign grant_idx  = grant_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_bft_leaf_inject_arb.sv
// Directed bench for bft_leaf_inject_arb in its default configuration
// (2 leaves, 1-bit payload, 3-bit packet, 4 ports, 4-deep FIFOs).
module tb_bft_leaf_inject_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_dest;
    logic [3:0]  req_payload;
    logic [3:0]  req_ready;
    logic        net_stall;
    logic [2:0]  bus_o;
    logic [1:0]  grant_idx;
    logic [15:0] sent_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bft_leaf_inject_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_payload(req_payload),
        .req_ready  (req_ready),
        .net_stall  (net_stall),
        .bus_o      (bus_o),
        .grant_idx  (grant_idx),
        .sent_count (sent_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] p, input logic v, input logic d, input logic pl);
        req_valid[p]   = v;
        req_dest[p]    = d;
        req_payload[p] = pl;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        net_stall = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_dest    = '0;
        req_payload = '0;
        net_stall   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset; a stall with nothing on the bus must be ignored.
        check("rst_grant", 32'(grant_idx), 0);
        net_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ready", 32'(req_ready), 32'hf);
            check("idle_bus", 32'(bus_o), 0);
            check("idle_sent", 32'(sent_count), 0);
        end
        net_stall = 1'b0;

        // Single packet: port 2, dest 1, payload 1 -> 3'b111 one edge after the push.
        drive(2, 1, 1, 1);
        tick();
        drive(2, 0, 0, 0);
        check("lat_not_yet", 32'(bus_o), 0);
        tick();
        check("single_bus", 32'(bus_o), 7);
        check("single_grant", 32'(grant_idx), 2);
        tick();
        check("single_bus_clear", 32'(bus_o), 0);
        check("single_sent", 32'(sent_count), 1);

        // All ports busy: port p sends dest=p[1], payload=p[0] -> packet 4+p.
        do_reset();
        for (int p = 0; p < 4; p++) drive(2'(p), 1, 1'(p >> 1), 1'(p));
        tick();
        for (int n = 0; n < 8; n++) begin
            tick();
            check("rr_grant", 32'(grant_idx), 32'(n % 4));
            check("rr_bus", 32'(bus_o), 32'(4 + n % 4));
        end
        tick();
        check("rr_sent8", 32'(sent_count), 8);

        // Stall hold: port 1 packet 3'b101 held while port 1 keeps pushing 3'b110.
        do_reset();
        drive(1, 1, 0, 1);
        drive(2, 1, 1, 1);
        tick();
        drive(2, 0, 0, 0);
        drive(1, 1, 1, 0);
        tick();
        check("hold_first_bus", 32'(bus_o), 5);
        check("hold_first_grant", 32'(grant_idx), 1);
        net_stall = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            check("hold_bus", 32'(bus_o), 5);
            check("hold_grant", 32'(grant_idx), 1);
            check("hold_ready1", 32'(req_ready[1]), (j < 3) ? 1 : 0);
        end
        check("hold_sent", 32'(sent_count), 0);
        drive(1, 0, 0, 0);
        net_stall = 1'b0;
        tick();
        check("release_sent", 32'(sent_count), 1);
        check("release_bus", 32'(bus_o), 7);
        check("release_grant", 32'(grant_idx), 2);
        tick();
        check("release2_sent", 32'(sent_count), 2);
        check("release2_bus", 32'(bus_o), 6);
        check("release2_grant", 32'(grant_idx), 1);

        // Full FIFO: port 3 packet held while port 0 takes 4 pushes; the 5th is refused.
        do_reset();
        drive(3, 1, 1, 1);
        tick();
        drive(3, 0, 0, 0);
        drive(0, 1, 0, 0);
        tick();
        check("full_held_bus", 32'(bus_o), 7);
        check("full_held_grant", 32'(grant_idx), 3);
        net_stall = 1'b1;
        drive(0, 1, 0, 1);
        tick();
        drive(0, 1, 1, 0);
        tick();
        drive(0, 1, 1, 1);
        tick();
        check("full_ready0", 32'(req_ready[0]), 0);
        drive(0, 1, 0, 0);
        tick();
        check("full_ready0_still", 32'(req_ready[0]), 0);
        check("full_bus_still", 32'(bus_o), 7);
        drive(0, 0, 0, 0);
        net_stall = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("drain_bus", 32'(bus_o), 32'(4 + n));
            check("drain_grant", 32'(grant_idx), 0);
        end
        tick();
        check("drain_empty", 32'(bus_o), 0);
        check("drain_sent", 32'(sent_count), 5);

        // Reset with queued packets and a held packet: everything is discarded.
        do_reset();
        drive(2, 1, 0, 1);
        drive(3, 1, 1, 0);
        tick();
        drive(2, 0, 0, 0);
        drive(3, 0, 0, 0);
        tick();
        check("pre_rst_bus", 32'(bus_o), 5);
        check("pre_rst_grant", 32'(grant_idx), 2);
        net_stall = 1'b1;
        drive(1, 1, 1, 1);
        tick();
        tick();
        drive(1, 0, 0, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_bus", 32'(bus_o), 0);
        check("mid_rst_grant", 32'(grant_idx), 0);
        check("mid_rst_ready", 32'(req_ready), 32'hf);
        check("mid_rst_sent", 32'(sent_count), 0);
        reset     = 1'b0;
        net_stall = 1'b0;
        drive(0, 1, 0, 0);
        drive(3, 1, 1, 1);
        tick();
        drive(0, 0, 0, 0);
        drive(3, 0, 0, 0);
        tick();
        check("post_rst_grant", 32'(grant_idx), 0);
        check("post_rst_bus", 32'(bus_o), 4);
        tick();
        check("post_rst_grant2", 32'(grant_idx), 3);
        check("post_rst_bus2", 32'(bus_o), 7);
        tick();
        check("post_rst_discard", 32'(bus_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bft_leaf_inject_arb.md
Name: bft_leaf_inject_arb

Overview:
- Leaf-side injection scheduler for the butterfly-fat-tree network.
- Shares one leaf packet bus into the tree between num_ports local requesters.
- Each requester gets a small FIFO; a round-robin arbiter drains the FIFOs into a registered output packet.
- Stalls are honoured: a packet the tree did not accept is re-presented unchanged.

Parameters:
- num_leaves, 2: leaves in the tree; addr_w = $clog2(num_leaves).
- payload_sz, 1: payload bits per packet.
- p_sz, 1+$clog2(num_leaves)+payload_sz: packet width = valid + address + payload.
- num_ports, 4: local requesters (≥2).
- fifo_depth, 4: entries per requester FIFO (power of 2, ≥2).

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- req_valid  input  num_ports  per-port request.
- req_dest  input  num_ports*addr_w  per-port destination leaf; port i at [i*addr_w+:addr_w].
- req_payload  input  num_ports*payload_sz  per-port payload; port i at [i*payload_sz+:payload_sz].
- req_ready  output  num_ports  per-port FIFO not full.
- net_stall  input  1  tree did not accept bus_o this cycle.
- bus_o  output  p_sz  packet into tree.
- grant_idx  output  $clog2(num_ports)  port whose packet is on bus_o.
- sent_count  output  16  packets accepted by the tree.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
- Packet format:
  - bus_o[p_sz-1] = valid.
  - bus_o[p_sz-2 -: addr_w] = dest.
  - bus_o[payload_sz-1:0] = payload.
  - An invalid packet drives all bits 0.
- Reset values:
  - All FIFOs empty, so req_ready = all 1s after reset.
  - bus_o = 0, grant_idx = 0, sent_count = 0.
  - rr_last = num_ports-1, so port 0 has first priority.
- Push:
  - req_ready[i] = !full[i], decoded from registered FIFO count only (no combinational path from the pop).
  - Push occurs when req_valid[i] & req_ready[i].
  - Full FIFO with a simultaneous pop: no push that cycle.
- Output register:
  - If bus_o valid & net_stall: HOLD. bus_o, grant_idx and rr_last are unchanged and no FIFO is popped.
  - Otherwise (bus_o invalid or accepted): search ports rr_last+1 … rr_last+num_ports (mod num_ports) for the first non-empty FIFO.
  - If one is found: pop its head; load bus_o = {1, dest, payload}; grant_idx = rr_last = that port.
  - If none is found: bus_o = 0; grant_idx and rr_last hold.
- net_stall while bus_o is invalid is ignored.
- sent_count increments (wraps at 2^16) on every cycle with bus_o valid & !net_stall.
- Latency:
  - Request sampled at edge k into an empty FIFO with idle output: bus_o valid after edge k+1.
  - Back-to-back from one port: one packet per cycle with no bubble, while its FIFO stays non-empty and there is no stall.
- Fairness: with all ports continuously busy, grants cycle 0,1,…,num_ports-1,0,…
- Stall persistence: the held packet stays bit-identical for any stall length. FIFOs keep accepting pushes until full.
- Reset mid-operation: queued and held packets are discarded. bus_o is 0 in the cycle after reset is sampled.
- FIFO pointers wrap modulo fifo_depth. Count runs 0…fifo_depth; full = (count == fifo_depth).

Decomposition:
- Package bft_pkg holds:
  - addr_w and p_sz helper functions.
  - Field offset constants (VALID_BIT, ADDR_LSB).
  - A pack_pkt(dest, payload) function, shared with t_switch_0 users.
- Sub-module bft_port_fifo:
  - Synchronous single-clock FIFO with parameters width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Instantiated num_ports times by generate.
  - Arbiter, output register and counter stay in the top module.

Test Plan:
- Reset release with no requests:
  - req_ready = 4'b1111, bus_o = 0, sent_count = 0 for 10 cycles.
  - net_stall = 1 is ignored.
- Single push, port 2, dest = 1, payload = 1 (num_leaves = 2, payload_sz = 1, p_sz = 3) at edge k:
  - bus_o = 3'b111 and grant_idx = 2 after edge k+1.
  - bus_o = 0 the next cycle.
  - sent_count = 1.
- All 4 ports pushing every cycle, no stall:
  - grant_idx sequence 0,1,2,3,0,1 with no invalid cycles.
  - After 8 accepted packets, sent_count = 8.
- Stall hold, with bus_o = 3'b101 from port 1:
  - Hold net_stall = 1 for 5 cycles: bus_o stays 3'b101 and grant_idx stays 1; no pop occurs.
  - Port 1 keeps pushing until full: req_ready[1] = 0 once count = 4.
  - After the stall drops: the held packet counts once, then the next grant is port 2 if it is non-empty.
- Full FIFO:
  - 4 pushes to port 0 while net_stall = 1 holds another port's packet: req_ready[0] = 0.
  - A fifth req_valid[0] is not accepted; after the stall drops, exactly 4 port-0 packets emerge, in order.
- Reset mid-stream with queues and a held packet:
  - bus_o = 0 the cycle after reset.
  - All req_ready = 1 and sent_count = 0.
  - The first post-reset grant is port 0.
